alu_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single 32-bit ALU result path among 8 requesters.
- Drives the 3-bit select of the 8:1 result multiplexer and a one-hot grant vector.
- Holds each grant until the ALU consumer signals completion, the requester withdraws, or a watchdog expires.
- Sits between the requester units and the ALU result mux; purely control, no datapath.

---
 rtl/alu_rr_arbiter_pkg.sv | 17 +
 rtl/alu_rr_arbiter_if.sv | 29 ++
 rtl/alu_rr_arbiter_rr_pick8.sv | 33 +++
 rtl/alu_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_rr_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_rr_arbiter_pkg.sv
// Shared constants and types for the ALU result-path round-robin arbiter.
// Fixed at 8 requesters because the downstream result mux has a 3-bit select.
package alu_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Requester/consumer side of the arbiter plus its observable state and pointer.
// The arbiter uses the slave modport; the requester/consumer side uses master.
//
// Handshake: req[i] is a level request held by requester i; a grant stays on
// gnt/sel until op_done pulses for one cycle, req[sel] drops, or the
// watchdog fires, in which case timeout pulses one cycle after the release.
interface alu_rr_arbiter_if;
  import alu_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic             op_done;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             timeout;
  state_t           state;
  logic [SEL_W-1:0] ptr;

  modport master (
    output req, op_done,
    input  gnt, sel, busy, timeout, state, ptr
  );

  modport slave (
    input  req, op_done,
    output gnt, sel, busy, timeout, state, ptr
  );

endinterface

// File: rtl/alu_rr_arbiter_rr_pick8.sv
// Circular priority search over 8 requests starting at ptr: rotate right by
// ptr, take the lowest set bit, and add ptr back modulo 8.
module rr_pick8
  import alu_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  assign dbl = {req, req};
  assign rot = dbl[ptr +: N_REQ];

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
  end

  assign idx = off + ptr;

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing the 32-bit ALU result path among 8 requesters.
// Grants are registered and held until op_done, withdrawal or watchdog expiry.
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_rr_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             to_q, to_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;

  logic [SEL_W-1:0] pick_ptr;
  logic             found;
  logic [SEL_W-1:0] pick_idx;
  logic             expire;
  logic             withdraw;
  logic             release_now;

  // On release the search starts just past the current winner, so the
  // re-arbitration in the same cycle already sees the updated pointer.
  assign pick_ptr = (state_q == BUSY) ? sel_q + SEL_W'(1) : ptr_q;

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (pick_idx)
  );

  assign expire      = (TIMEOUT != 0) && (wdog_q == WD_LAST);
  assign withdraw    = !bus.req[sel_q];
  assign release_now = bus.op_done || withdraw || expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      ptr_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    to_d    = 1'b0;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gnt_d   = onehot(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          wdog_d  = '0;
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end

      BUSY: begin
        if (release_now) begin
          ptr_d = pick_ptr;
          // Only a pure watchdog release is reported; op_done or a withdraw
          // in the same cycle means the grant ended normally.
          to_d  = expire && !bus.op_done && !withdraw;
          if (found) begin
            gnt_d  = onehot(pick_idx);
            sel_d  = pick_idx;
            busy_d = 1'b1;
            wdog_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            wdog_d  = '0;
          end
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = to_q;
  assign bus.state   = state_q;
  assign bus.ptr     = ptr_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_busy_gnt:    assert property (@(posedge clk) disable iff (!rst_n) busy_q == (|gnt_q));
  a_sel_gnt:     assert property (@(posedge clk) disable iff (!rst_n) busy_q |-> gnt_q == onehot(sel_q));

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: reset, single grant, rotation, wrap,
// watchdog, withdraw and asynchronous mid-grant reset.
module tb_alu_rr_arbiter;
  import alu_rr_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [2:0] exp_q[$];

  alu_rr_arbiter_if bus();

  alu_rr_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation ran past its time budget");
    $fatal(1, "time budget exceeded");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; check invariants each cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv_busy", 32'(bus.busy), 32'(|bus.gnt));
    if (bus.busy) chk("inv_onehot", 32'(bus.gnt), 32'(8'd1 << bus.sel));
    else          chk("inv_idle_gnt", 32'(bus.gnt), 32'h0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [2:0] e;
    checks   = 0;
    failures = 0;

    // Reset / idle
    rst_n       = 1'b0;
    bus.req     = 8'hFF;
    bus.op_done = 1'b0;
    ticks(3);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);
    rst_n   = 1'b1;
    bus.req = 8'h00;
    ticks(2);
    chk("idle_gnt", 32'(bus.gnt), 32'h0);
    chk("idle_state", 32'(bus.state), 32'(IDLE));
    chk("idle_timeout", 32'(bus.timeout), 32'h0);

    // Single request, then re-grant of the same requester after op_done
    bus.req = 8'h20;
    tick();
    chk("single_gnt", 32'(bus.gnt), 32'h20);
    chk("single_sel", 32'(bus.sel), 32'd5);
    chk("single_busy", 32'(bus.busy), 32'h1);
    chk("single_ptr", 32'(bus.ptr), 32'd0);
    ticks(2);
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    chk("regrant_gnt", 32'(bus.gnt), 32'h20);
    chk("regrant_ptr", 32'(bus.ptr), 32'd6);
    bus.req = 8'h00;
    tick();
    chk("withdraw_idle_gnt", 32'(bus.gnt), 32'h0);
    chk("withdraw_idle_sel", 32'(bus.sel), 32'd5);
    chk("withdraw_idle_ptr", 32'(bus.ptr), 32'd6);

    // Rotation from pointer 0 with all requesting
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(3'(k));
    exp_q.push_back(3'd0);
    bus.req = 8'hFF;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rot_sel", 32'(bus.sel), 32'(e));
      chk("rot_gnt", 32'(bus.gnt), 32'(8'd1 << e));
      chk("rot_busy", 32'(bus.busy), 32'h1);
      tick();
      chk("rot_hold", 32'(bus.gnt), 32'(8'd1 << e));
      bus.op_done = 1'b1;
      tick();
      bus.op_done = 1'b0;
    end
    chk("rot_next_sel", 32'(bus.sel), 32'd1);
    bus.req = 8'h00;
    tick();
    chk("rot_end_ptr", 32'(bus.ptr), 32'd2);

    // Wrap-around: grant 6 (pointer becomes 7), then 0, then 6
    bus.req = 8'h40;
    tick();
    chk("wrap_first_sel", 32'(bus.sel), 32'd6);
    bus.req     = 8'h41;
    bus.op_done = 1'b1;
    tick();
    chk("wrap_sel0", 32'(bus.sel), 32'd0);
    chk("wrap_gnt0", 32'(bus.gnt), 32'h01);
    chk("wrap_ptr7", 32'(bus.ptr), 32'd7);
    tick();
    bus.op_done = 1'b0;
    chk("wrap_sel6", 32'(bus.sel), 32'd6);
    chk("wrap_gnt6", 32'(bus.gnt), 32'h40);
    chk("wrap_ptr1", 32'(bus.ptr), 32'd1);
    bus.req = 8'h00;
    tick();
    chk("wrap_idle_ptr", 32'(bus.ptr), 32'd7);

    // Watchdog: grant held 16 cycles, then one-cycle timeout pulse
    bus.req = 8'h04;
    tick();
    for (int c = 0; c < 16; c++) begin
      chk("wd_hold_gnt", 32'(bus.gnt), 32'h04);
      chk("wd_hold_timeout", 32'(bus.timeout), 32'h0);
      tick();
    end
    chk("wd_pulse", 32'(bus.timeout), 32'h1);
    chk("wd_ptr", 32'(bus.ptr), 32'd3);
    chk("wd_regrant", 32'(bus.gnt), 32'h04);
    tick();
    chk("wd_pulse_end", 32'(bus.timeout), 32'h0);
    // op_done on the expiry cycle suppresses the pulse
    ticks(14);
    chk("wd2_pre_timeout", 32'(bus.timeout), 32'h0);
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    chk("wd2_no_pulse", 32'(bus.timeout), 32'h0);
    chk("wd2_regrant", 32'(bus.gnt), 32'h04);
    bus.req = 8'h00;
    tick();
    chk("wd2_idle", 32'(bus.busy), 32'h0);

    // Withdraw with a pending request, then asynchronous reset mid-grant
    bus.req = 8'h04;
    tick();
    chk("wdr_gnt2", 32'(bus.gnt), 32'h04);
    bus.req = 8'h24;
    tick();
    chk("wdr_hold", 32'(bus.gnt), 32'h04);
    bus.req = 8'h20;
    tick();
    chk("wdr_gnt5", 32'(bus.gnt), 32'h20);
    chk("wdr_sel5", 32'(bus.sel), 32'd5);
    ticks(3);
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(bus.gnt), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_timeout", 32'(bus.timeout), 32'h0);
    chk("arst_state", 32'(bus.state), 32'(IDLE));
    tick();
    bus.req = 8'h00;
    rst_n   = 1'b1;
    tick();
    chk("post_rst_timeout", 32'(bus.timeout), 32'h0);
    chk("post_rst_gnt", 32'(bus.gnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
